// File: rtl/decoder_3to8_pkg.sv
// Shared widths and a reference decode helper for the 3-to-8 decoder slice.
package decoder_3to8_pkg;

  localparam int unsigned DEC_WIDTH = 8;
  localparam int unsigned SEL_WIDTH = 3;

  function automatic logic [DEC_WIDTH-1:0] onehot_decode(
    input logic                 en,
    input logic [SEL_WIDTH-1:0] sel
  );
    logic [DEC_WIDTH-1:0] v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Pure combinational select+enable to one-hot vector.
module decoder_3to8_core
  import decoder_3to8_pkg::*;
(
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic                 en,
  output logic [DEC_WIDTH-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_3to8.sv
// 3-to-8 line decoder, active-high enable and outputs, optional output register.
module decoder_3to8
  import decoder_3to8_pkg::*;
#(
  parameter int unsigned REGISTER_OUT = 0
) (
  output logic Y7,
  output logic Y6,
  output logic Y5,
  output logic Y4,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic en,
  input  logic clk,
  input  logic rst
);

  logic [SEL_WIDTH-1:0] sel;
  logic [DEC_WIDTH-1:0] dec;
  logic [DEC_WIDTH-1:0] y;

  assign sel = {A, B, C};

  decoder_3to8_core u_core (
    .sel (sel),
    .en  (en),
    .dec (dec)
  );

  if (REGISTER_OUT != 0) begin : g_reg
    logic [DEC_WIDTH-1:0] y_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) y_q <= '0;
      else     y_q <= dec;
    end

    assign y = y_q;
  end else begin : g_comb
    // clk/rst are ports only for positional compatibility; they may float here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign y = dec;
  end

  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y;

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench: combinational and registered decoder instances driven in parallel.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, en = 1'b0;
  logic [7:0] yc;
  logic [7:0] yr;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] q_comb[$];
  logic [7:0] q_reg[$];
  logic [7:0] reg_now = 8'h00;

  always #5 clk = ~clk;

  decoder_3to8 #(.REGISTER_OUT(0)) dut_comb (
    .Y7(yc[7]), .Y6(yc[6]), .Y5(yc[5]), .Y4(yc[4]),
    .Y3(yc[3]), .Y2(yc[2]), .Y1(yc[1]), .Y0(yc[0]),
    .A(a), .B(b), .C(c), .en(en), .clk(clk), .rst(rst)
  );

  decoder_3to8 #(.REGISTER_OUT(1)) dut_reg (
    .Y7(yr[7]), .Y6(yr[6]), .Y5(yr[5]), .Y4(yr[4]),
    .Y3(yr[3]), .Y2(yr[2]), .Y1(yr[1]), .Y0(yr[0]),
    .A(a), .B(b), .C(c), .en(en), .clk(clk), .rst(rst)
  );

  function automatic logic [7:0] model(input logic e, input logic [2:0] s);
    logic [7:0] one;
    one = 8'd1;
    return e ? (one << s) : 8'd0;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pop_exp(input string tag, inout logic [7:0] q[$], output logic [7:0] v);
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
      v = 8'hxx;
    end else begin
      v = q.pop_front();
    end
  endtask

  task automatic apply(input logic e, input logic [2:0] s);
    logic [7:0] x;
    @(negedge clk);
    en = e;
    {a, b, c} = s;
    q_comb.push_back(model(e, s));
    q_reg.push_back(model(e, s));
    #1;
    pop_exp("comb", q_comb, x);
    check_eq("comb", yc, x);
    check_eq("popcnt", 8'($countones(yc)), {7'd0, e});
    check_eq("reg_hold", yr, reg_now);
    @(posedge clk);
    #1;
    pop_exp("reg", q_reg, x);
    reg_now = x;
    check_eq("reg", yr, reg_now);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state; combinational copy must ignore rst entirely.
    en = 1'b1;
    {a, b, c} = 3'b011;
    #1;
    check_eq("rst_reg", yr, 8'h00);
    check_eq("rst_comb", yc, 8'h08);
    @(posedge clk);
    #1;
    check_eq("rst_hold", yr, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_release", yr, 8'h00);
    @(posedge clk);
    #1;
    check_eq("rst_first_load", yr, 8'h08);
    reg_now = 8'h08;

    for (int unsigned i = 0; i < 8; i++) apply(1'b0, 3'(i));
    apply(1'b1, 3'b000);
    apply(1'b1, 3'b010);
    apply(1'b1, 3'b100);
    apply(1'b1, 3'b110);
    for (int unsigned i = 0; i < 8; i++) apply(1'b1, 3'(i));
    apply(1'b1, 3'b110);
    apply(1'b0, 3'b110);

    // Mid-operation asynchronous reset between edges.
    apply(1'b1, 3'b011);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_clr", yr, 8'h00);
    check_eq("async_comb", yc, 8'h08);
    @(posedge clk);
    #1;
    check_eq("async_hold", yr, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("async_release", yr, 8'h00);
    @(posedge clk);
    #1;
    check_eq("async_reload", yr, 8'h08);
    reg_now = 8'h08;
    apply(1'b1, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
